// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (A - B) mod 2^WIDTH one bit per
// clock, LSB first, with a registered borrow. Operands are parallel-loaded on
// the accepting edge; the full difference and final borrow are presented
// together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             diff_bit,
    output logic             diff_bit_valid
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sr_shifted;

    // Full-subtractor slice for the bit currently selected by the counter.
    always_comb begin
        a_bit      = a_q[cnt_q];
        b_bit      = b_q[cnt_q];
        d_bit      = a_bit ^ b_bit ^ br_q;
        br_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        sr_shifted = {d_bit, sr_q[WIDTH-1:1]};
    end

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sr_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sr_d    = sr_shifted;
                br_d    = br_next;
                bit_d   = d_bit;
                valid_d = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d   = sr_shifted;
                    borrow_d = br_next;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign diff_out       = diff_q;
    assign borrow_out     = borrow_q;
    assign diff_bit       = bit_q;
    assign diff_bit_valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected values come
// from plain modular arithmetic on the operands.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic         diff_bit;
    logic         diff_bit_valid;

    int unsigned total = 0;
    int unsigned bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a_in           (a_in),
        .b_in           (b_in),
        .busy           (busy),
        .done           (done),
        .diff_out       (diff_out),
        .borrow_out     (borrow_out),
        .diff_bit       (diff_bit),
        .diff_bit_valid (diff_bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete operation from IDLE; optionally wiggles operands and
    // re-asserts start while running, which must have no effect.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, input string tag);
        logic [W-1:0] ed;
        logic         eb;
        ed = a - b;
        eb = (a < b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            a_in = W'($urandom);
            b_in = W'($urandom);
        end
        total++;
        if ({busy, done, diff_bit_valid} !== 3'b100) begin
            bad++;
            $display("FAIL %s accept: busy/done/valid=%b expected 100", tag, {busy, done, diff_bit_valid});
        end
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            if (disturb && k == 1) begin
                start = 1'b1;
                a_in  = 8'h10;
                b_in  = 8'h01;
            end
            if (disturb && k == 4) start = 1'b0;
            total++;
            if (diff_bit_valid !== 1'b1 || diff_bit !== ed[k]) begin
                bad++;
                $display("FAIL %s bit%0d: valid=%b bit=%b expected valid=1 bit=%b", tag, k, diff_bit_valid, diff_bit, ed[k]);
            end
            total++;
            if (done !== (k == W - 1)) begin
                bad++;
                $display("FAIL %s done_timing k=%0d: done=%b expected %b", tag, k, done, (k == W - 1));
            end
        end
        total++;
        if (diff_out !== ed || borrow_out !== eb) begin
            bad++;
            $display("FAIL %s result: diff=%h borrow=%b expected diff=%h borrow=%b", tag, diff_out, borrow_out, ed, eb);
        end
        @(negedge clk);
        total++;
        if ({busy, done, diff_bit_valid} !== 3'b000 || diff_out !== ed || borrow_out !== eb) begin
            bad++;
            $display("FAIL %s after_done: busy/done/valid=%b diff=%h borrow=%b expected 000 %h %b", tag, {busy, done, diff_bit_valid}, diff_out, borrow_out, ed, eb);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #2;
        total++;
        if ({busy, done, diff_out, borrow_out, diff_bit, diff_bit_valid} !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b bit=%b valid=%b expected all 0", busy, done, diff_out, borrow_out, diff_bit, diff_bit_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, diff_bit_valid} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: busy/done/valid=%b expected 000", {busy, done, diff_bit_valid});
        end
    endtask

    task automatic test_directed();
        run_op(8'h05, 8'h03, 1'b0, "5m3");
        run_op(8'h03, 8'h05, 1'b0, "3m5");
        run_op(8'h00, 8'h01, 1'b0, "0m1");
        run_op(8'hA5, 8'hA5, 1'b0, "eq");
        run_op(8'hFF, 8'h00, 1'b0, "ffm0");
    endtask

    task automatic test_start_ignored();
        run_op(8'h37, 8'h12, 1'b1, "ignore_start");
        run_op(8'h10, 8'h01, 1'b0, "fresh_start");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a_in  = 8'h3C;
        b_in  = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done, diff_out, borrow_out, diff_bit, diff_bit_valid} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b diff=%h borrow=%b bit=%b valid=%b expected all 0", busy, done, diff_out, borrow_out, diff_bit, diff_bit_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_no_done cyc%0d: done=%b busy=%b expected 0 0", k, done, busy);
            end
        end
        run_op(8'h80, 8'h7F, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_op(W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    // start held high: accepts every W+2 cycles, busy drops for one cycle.
    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ed;
        a  = W'($urandom);
        b  = W'($urandom);
        ed = a - b;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (done !== ((i % (W + 2)) == W) || busy !== ((i % (W + 2)) != W + 1)) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: done=%b busy=%b expected done=%b busy=%b", i, done, busy, ((i % (W + 2)) == W), ((i % (W + 2)) != W + 1));
            end
            if (done === 1'b1) begin
                total++;
                if (diff_out !== ed || borrow_out !== (a < b)) begin
                    bad++;
                    $display("FAIL back_to_back_result cyc%0d: diff=%h borrow=%b expected %h %b", i, diff_out, borrow_out, ed, (a < b));
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < W + 2; k++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
